router_pkt_fifo: RTL and testbench
==================================

Name: router_pkt_fifo

Overview:
Parametrised, packet-aware output FIFO for the router, one instance per destination port. It is the successor to the fixed 16x8 router_fifo. It stores each byte with its header marker (lfd), tracks packet length on the read side from the header's length field, and clears its output when a packet is fully drained. It adds level, almost-full and sticky error reporting, consumed by the router sync/FSM blocks.

Parameters:
DATA_WIDTH, 8, byte width on data_in/data_out; header = {length, address}.
DEPTH, 16, number of entries; power of two, >=4.
ADDR_BITS, 2, width of the address field in header bits [ADDR_BITS-1:0]; length field LEN_W = DATA_WIDTH-ADDR_BITS.
AF_THRESH, DEPTH-2, fill level at or above which almost_full asserts; 1..DEPTH.

Ports:
clock  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
soft_reset  in  1  synchronous flush, from the router sync block timeout
write_enb  in  1  write request
read_enb  in  1  read request
lfd_state  in  1  marks current data_in as a header byte
data_in  in  DATA_WIDTH  write data
data_out  out  DATA_WIDTH  registered read data
data_valid  out  1  data_out holds a byte read the previous cycle
full  out  1  fill_level == DEPTH
empty  out  1  fill_level == 0
almost_full  out  1  fill_level >= AF_THRESH
fill_level  out  log2(DEPTH)+1  entries stored
pkt_busy  out  1  read-side remaining-byte counter nonzero
overflow_err  out  1  sticky: write_enb while full
framing_err  out  1  sticky: non-header byte read while counter == 0

Behaviour:
- resetn low (async): pointers, fill_level, counter and data_out = 0. data_valid, full, pkt_busy, almost_full, overflow_err and framing_err = 0. empty = 1. Memory contents are not reset.
- soft_reset high at an edge: same clearing as resetn, synchronous, one cycle. It overrides any write or read that cycle. Sticky errors are also cleared.
- Entry = {lfd_state, data_in}, DATA_WIDTH+1 bits. Pointers wrap modulo DEPTH with an extra wrap bit; full/empty derive from the pointers.
- Write accepted iff write_enb && !full. Write while full: data is dropped and overflow_err sets.
- Read accepted iff read_enb && !empty. Read while empty: no effect, no error.
- Simultaneous accepted read and write: fill_level unchanged. When full, only the read is accepted; when empty, only the write is accepted (no fall-through).
- Read latency: 1 cycle. data_out and data_valid update on the edge that accepts the read.
- Read-side counter (LEN_W+1 bits):
  - Accepted read of an lfd entry: counter = length+1 (payload + parity); pkt_busy=1. This applies even if the counter was nonzero; the new header restarts the count.
  - Accepted read of a non-lfd entry: counter decrements, saturating at 0. If the counter was already 0, framing_err sets.
  - Header length 0: counter = 1 (parity only).
- Output idle: in a cycle with no accepted read, data_valid=0. If the counter == 0, data_out clears to 0; otherwise data_out holds its value.
- Status outputs (full, empty, almost_full, fill_level) are registered and reflect state after the current edge.

Decomposition:
- Package router_pkg: default DATA_WIDTH and ADDR_BITS, LEN_W localparam, and functions hdr_len(byte) and hdr_addr(byte).
- Sub-module router_fifo_mem: DEPTH x (DATA_WIDTH+1) storage array.
  - One synchronous write port, one registered read port, no reset.
  - Pointers, flags and the counter remain in router_pkt_fifo.

Test Plan:
- Reset then soft reset, then write header 8'h11 (len 4, addr 1) with lfd=1, payloads A1 B2 C3 D4, parity 5E -> fill_level=6, empty=0. Then read 6 cycles -> data_out 11,A1,B2,C3,D4,5E one cycle after each read_enb; pkt_busy falls after 5E. Next idle cycle: data_out=0, data_valid=0.
- Write 16 bytes with write_enb held 17 cycles -> full=1 at 16; 17th byte dropped, overflow_err=1. almost_full=1 from fill_level 14.
- At full, assert write_enb and read_enb together -> one read, write rejected, fill_level=15. Repeat when not full -> fill_level unchanged.
- Write 5 bytes, pulse soft_reset mid-read (after 2 reads) -> next cycle empty=1, fill_level=0, data_out=0, pkt_busy=0, errors=0.
- Assert resetn low asynchronously mid-write, between clock edges -> outputs clear immediately, without waiting for a clock edge.
- Read a non-lfd byte with counter 0 -> framing_err=1. Header 8'h01 (len 0) -> pkt_busy drops after 1 more read. Regress with DATA_WIDTH=16, DEPTH=64 -> same sequences pass.

Source files
------------

// File: rtl/router_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | router_pkg                                                         |
// | Shared defaults and header field helpers for the router FIFOs.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package router_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_BITS  = 2;
  localparam int LEN_W          = DEF_DATA_WIDTH - DEF_ADDR_BITS;

  // Header layout is {length, address}; widths are passed in so any instance size can share these.
  function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int addr_bits);
    return hdr >> addr_bits;
  endfunction

  function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int addr_bits);
    return hdr & ((32'd1 << addr_bits) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_fifo_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | router_fifo_mem                                                    |
// | DEPTH x WIDTH storage, one sync write port, one registered read.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module router_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write-to-read bypass keeps the registered head entry coherent when the slot is written this cycle.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_we && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/router_pkt_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | router_pkt_fifo                                                    |
// | Packet-aware output FIFO with length tracking and status flags.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int AF_THRESH  = DEPTH - 2
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    soft_reset,
  input  logic                    write_enb,
  input  logic                    read_enb,
  input  logic                    lfd_state,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    pkt_busy,
  output logic                    overflow_err,
  output logic                    framing_err
);

  localparam int               c_aw      = $clog2(DEPTH);
  localparam int               c_len_w   = DATA_WIDTH - ADDR_BITS;
  localparam int               c_ent_w   = DATA_WIDTH + 1;
  localparam logic [c_aw:0]    c_af      = (c_aw + 1)'(AF_THRESH);
  localparam logic [c_aw:0]    c_ptr_one = (c_aw + 1)'(1);
  localparam logic [c_len_w:0] c_cnt_one = (c_len_w + 1)'(1);

  logic [c_aw:0]           r_wr_ptr;
  logic [c_aw:0]           r_rd_ptr;
  logic [c_aw:0]           r_fill;
  logic                    r_full;
  logic                    r_empty;
  logic                    r_af;
  logic [c_len_w:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_dout;
  logic                    r_dv;
  logic                    r_ovf;
  logic                    r_ferr;

  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic [c_aw:0]           w_wr_ptr_nxt;
  logic [c_aw:0]           w_rd_ptr_nxt;
  logic [c_aw:0]           w_fill_nxt;
  logic [c_ent_w-1:0]      w_head;
  logic [c_len_w-1:0]      w_len;
  logic [c_len_w:0]        w_cnt_nxt;

  always_comb begin
    w_wr_acc     = write_enb && !r_full;
    w_rd_acc     = read_enb && !r_empty;
    w_wr_ptr_nxt = w_wr_acc ? (r_wr_ptr + c_ptr_one) : r_wr_ptr;
    w_rd_ptr_nxt = w_rd_acc ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;
    w_fill_nxt   = w_wr_ptr_nxt - w_rd_ptr_nxt;
    w_len        = c_len_w'(hdr_len(32'(w_head[DATA_WIDTH-1:0]), ADDR_BITS));
    // A header always restarts the count: payload bytes plus the trailing parity byte.
    w_cnt_nxt    = r_cnt;
    if (w_rd_acc) begin
      if (w_head[DATA_WIDTH]) begin
        w_cnt_nxt = {1'b0, w_len} + c_cnt_one;
      end else if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - c_cnt_one;
      end
    end
  end

  // Read address runs one step ahead so the registered output always holds the head entry.
  router_fifo_mem #(
    .WIDTH (c_ent_w),
    .DEPTH (DEPTH),
    .AW    (c_aw)
  ) u_mem (
    .clk     (clock),
    .i_we    (w_wr_acc && !soft_reset),
    .i_waddr (r_wr_ptr[c_aw-1:0]),
    .i_wdata ({lfd_state, data_in}),
    .i_raddr (w_rd_ptr_nxt[c_aw-1:0]),
    .o_rdata (w_head)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_cnt    <= '0;
      r_dout   <= '0;
      r_dv     <= 1'b0;
      r_ovf    <= 1'b0;
      r_ferr   <= 1'b0;
    end else if (soft_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_cnt    <= '0;
      r_dout   <= '0;
      r_dv     <= 1'b0;
      r_ovf    <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_fill   <= w_fill_nxt;
      r_full   <= (w_wr_ptr_nxt[c_aw] != w_rd_ptr_nxt[c_aw]) &&
                  (w_wr_ptr_nxt[c_aw-1:0] == w_rd_ptr_nxt[c_aw-1:0]);
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_af     <= (w_fill_nxt >= c_af);
      r_cnt    <= w_cnt_nxt;
      r_dv     <= w_rd_acc;
      if (w_rd_acc) begin
        r_dout <= w_head[DATA_WIDTH-1:0];
      end else if (r_cnt == '0) begin
        r_dout <= '0;
      end
      if (write_enb && r_full) begin
        r_ovf <= 1'b1;
      end
      if (w_rd_acc && !w_head[DATA_WIDTH] && (r_cnt == '0)) begin
        r_ferr <= 1'b1;
      end
    end
  end

  assign data_out     = r_dout;
  assign data_valid   = r_dv;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign fill_level   = r_fill;
  assign pkt_busy     = (r_cnt != '0);
  assign overflow_err = r_ovf;
  assign framing_err  = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_router_pkt_fifo                                                 |
// | Directed + randomized bench against a queue-based packet model.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_router_pkt_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AB    = 2;
  localparam int AF    = DEPTH - 2;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic          clock;
  logic          resetn;
  logic          soft_reset;
  logic          write_enb;
  logic          read_enb;
  logic          lfd_state;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [FW-1:0] fill_level;
  logic          pkt_busy;
  logic          overflow_err;
  logic          framing_err;

  router_pkt_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_BITS  (AB),
    .AF_THRESH  (AF)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .soft_reset   (soft_reset),
    .write_enb    (write_enb),
    .read_enb     (read_enb),
    .lfd_state    (lfd_state),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .fill_level   (fill_level),
    .pkt_busy     (pkt_busy),
    .overflow_err (overflow_err),
    .framing_err  (framing_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a plain queue of {lfd, byte} plus the packet byte counter.
  logic [DW:0]   q[$];
  int            m_cnt;
  logic [DW-1:0] m_dout;
  bit            m_dv;
  bit            m_ovf;
  bit            m_ferr;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt  = 0;
    m_dout = '0;
    m_dv   = 0;
    m_ovf  = 0;
    m_ferr = 0;
  endtask

  task automatic model_step();
    int          sz;
    bit          wacc;
    bit          racc;
    logic [DW:0] e;
    if (!resetn || soft_reset) begin
      model_reset();
    end else begin
      sz   = q.size();
      wacc = write_enb && (sz < DEPTH);
      racc = read_enb && (sz > 0);
      if (write_enb && sz == DEPTH) m_ovf = 1;
      if (racc) begin
        e      = q.pop_front();
        m_dout = e[DW-1:0];
        m_dv   = 1;
        if (e[DW]) m_cnt = int'(e[DW-1:0] >> AB) + 1;
        else if (m_cnt == 0) m_ferr = 1;
        else m_cnt = m_cnt - 1;
      end else begin
        m_dv = 0;
        if (m_cnt == 0) m_dout = '0;
      end
      if (wacc) q.push_back({lfd_state, data_in});
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = q.size();
    chk("data_out",     data_out,     m_dout);
    chk("data_valid",   data_valid,   m_dv);
    chk("full",         full,         sz == DEPTH);
    chk("empty",        empty,        sz == 0);
    chk("almost_full",  almost_full,  sz >= AF);
    chk("fill_level",   fill_level,   sz);
    chk("pkt_busy",     pkt_busy,     m_cnt != 0);
    chk("overflow_err", overflow_err, m_ovf);
    chk("framing_err",  framing_err,  m_ferr);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic drive(input bit we, input bit re, input bit lfd, input logic [DW-1:0] d,
                       input bit sr = 0);
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = d;
    soft_reset = sr;
    cycle();
  endtask

  logic [DW-1:0] pkt  [6];
  bit            busy [6];
  bit            bias_wr;

  initial begin
    pkt  = '{8'h11, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h5E};
    busy = '{1, 1, 1, 1, 1, 0};
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = '0;
    model_reset();
    cycle();
    cycle();
    chk("reset_empty", empty, 1'b1);
    chk("reset_dout",  data_out, 8'h00);
    resetn = 1'b1;

    // Packet with header 0x11 (len 4, addr 1) written and drained.
    drive(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 6; i++) drive(1, 0, i == 0, pkt[i]);
    chk("fill_after_pkt", fill_level, 6);
    chk("nonempty_after_pkt", empty, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 8'h00);
      chk("pkt_byte", data_out, pkt[i]);
      chk("pkt_busy_seq", pkt_busy, busy[i]);
    end
    drive(0, 0, 0, 8'h00);
    chk("idle_dout", data_out, 8'h00);
    chk("idle_dv", data_valid, 1'b0);

    // Fill to full and one extra write.
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, DW'($urandom));
      if (i == 12) chk("af_at_13", almost_full, 1'b0);
      if (i == 13) chk("af_at_14", almost_full, 1'b1);
    end
    chk("full_at_16", full, 1'b1);
    chk("fill_16", fill_level, 16);
    chk("overflow_set", overflow_err, 1'b1);

    // Simultaneous read/write, at full then not full.
    drive(1, 1, 0, 8'h42);
    chk("rw_at_full", fill_level, 15);
    drive(1, 1, 0, 8'h43);
    chk("rw_not_full", fill_level, 15);
    for (int i = 0; i < 15; i++) drive(0, 1, 0, 8'h00);

    // Soft reset in the middle of draining a packet.
    drive(1, 0, 1, 8'h10);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, DW'($urandom));
    drive(0, 1, 0, 8'h00);
    drive(0, 1, 0, 8'h00);
    chk("busy_before_sr", pkt_busy, 1'b1);
    drive(0, 1, 0, 8'h00, 1);
    soft_reset = 1'b0;
    chk("sr_empty", empty, 1'b1);
    chk("sr_fill", fill_level, 0);
    chk("sr_dout", data_out, 8'h00);
    chk("sr_busy", pkt_busy, 1'b0);
    chk("sr_ovf", overflow_err, 1'b0);
    chk("sr_ferr", framing_err, 1'b0);

    // Asynchronous reset asserted between clock edges during a write burst.
    drive(1, 0, 1, 8'h15);
    drive(1, 0, 0, 8'h66);
    write_enb = 1'b1; data_in = 8'h77; lfd_state = 1'b0;
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("async_fill", fill_level, 0);
    chk("async_empty", empty, 1'b1);
    chk("async_busy", pkt_busy, 1'b0);
    check_outputs();
    cycle();
    resetn = 1'b1;

    // Framing error and zero-length header.
    drive(1, 0, 0, 8'h33);
    drive(0, 1, 0, 8'h00);
    chk("framing_set", framing_err, 1'b1);
    drive(1, 0, 1, 8'h01);
    drive(1, 0, 0, 8'h77);
    drive(0, 1, 0, 8'h00);
    chk("len0_busy", pkt_busy, 1'b1);
    drive(0, 1, 0, 8'h00);
    chk("len0_done", pkt_busy, 1'b0);
    chk("len0_parity", data_out, 8'h77);

    // Randomized traffic with alternating fill/drain bias.
    bias_wr = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) bias_wr = ~bias_wr;
      drive(bias_wr ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0),
            bias_wr ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0),
            $urandom_range(4, 0) == 0,
            DW'($urandom),
            $urandom_range(99, 0) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
